// File: rtl/mem_arb_pkg.sv
// Shared types for the core/debug memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_ACCESS} arbstate_t;

    typedef enum logic {OWN_CORE = 1'b0, OWN_DBG = 1'b1} owner_t;

    localparam int unsigned MAX_WAIT = 15;

endpackage

// File: rtl/arb_wait_counter.sv
// Down-counter timing one memory access; loads at grant, stops at zero.
module arb_wait_counter (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [3:0] i_value,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [3:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory between the core (C) and debug/DMA (D)
// ports with 2-way round robin; one access per WAIT_CYCLES+1 cycles.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_adr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ack,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_adr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner
);

    if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > MAX_WAIT)) begin : g_bad_wait
        $error("mem_port_arbiter: WAIT_CYCLES must be in 1..15");
    end

    localparam logic [3:0] LP_CNT_INIT = 4'(WAIT_CYCLES - 1);

    arbstate_t     r_state, w_next_state;
    owner_t        r_owner, w_grant;
    logic          w_load, w_done, w_zero;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_adr;
    logic [DW-1:0] w_sel_wdata;
    logic          r_we;
    logic          r_mem_en, r_mem_we;
    logic [AW-1:0] r_mem_adr;
    logic [DW-1:0] r_mem_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Contention goes to the port that did not win last time.
    always_comb begin
        w_next_state = r_state;
        w_grant      = r_owner;
        w_load       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (c_req || d_req) begin
                    w_load       = 1'b1;
                    w_next_state = ARB_ACCESS;
                    if (c_req && d_req) begin
                        w_grant = (r_owner == OWN_CORE) ? OWN_DBG : OWN_CORE;
                    end else begin
                        w_grant = d_req ? OWN_DBG : OWN_CORE;
                    end
                end
            end
            ARB_ACCESS: begin
                if (w_zero) begin
                    w_done       = 1'b1;
                    w_next_state = ARB_IDLE;
                end
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    assign w_sel_we    = (w_grant == OWN_DBG) ? d_we    : c_we;
    assign w_sel_adr   = (w_grant == OWN_DBG) ? d_adr   : c_adr;
    assign w_sel_wdata = (w_grant == OWN_DBG) ? d_wdata : c_wdata;

    arb_wait_counter u_wait_counter (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_load  (w_load),
        .i_value (LP_CNT_INIT),
        .i_dec   (r_state == ARB_ACCESS),
        .o_zero  (w_zero)
    );

    // mem_we is a single-cycle strobe; r_we keeps the access type for rdata gating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner     <= OWN_DBG;
            r_we        <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_adr   <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_load) begin
                r_owner     <= w_grant;
                r_we        <= w_sel_we;
                r_mem_en    <= 1'b1;
                r_mem_we    <= w_sel_we;
                r_mem_adr   <= w_sel_adr;
                r_mem_wdata <= w_sel_wdata;
            end else if (w_done) begin
                r_mem_en <= 1'b0;
            end
        end
    end

    assign c_ack     = w_done && (r_owner == OWN_CORE);
    assign d_ack     = w_done && (r_owner == OWN_DBG);
    assign c_rdata   = (c_ack && !r_we) ? mem_rdata : '0;
    assign d_rdata   = (d_ack && !r_we) ? mem_rdata : '0;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_adr   = r_mem_adr;
    assign mem_wdata = r_mem_wdata;
    assign owner     = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (WAIT_CYCLES=2) plus latency checks at 1 and 15.
module tb_mem_port_arbiter;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;

    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_adr, c_wdata, d_adr, d_wdata;
    logic        c_ack, d_ack, mem_en, mem_we, owner;
    logic [31:0] c_rdata, d_rdata, mem_adr, mem_wdata, mem_rdata;

    logic        x1_c_req, x1_c_ack, x1_d_ack, x1_mem_en, x1_mem_we, x1_owner;
    logic [31:0] x1_c_rdata, x1_d_rdata, x1_mem_adr, x1_mem_wdata;
    logic        x15_c_req, x15_c_ack, x15_d_ack, x15_mem_en, x15_mem_we, x15_owner;
    logic [31:0] x15_c_rdata, x15_d_rdata, x15_mem_adr, x15_mem_wdata;
    logic        zero_b = 1'b0;
    logic [31:0] zero_w = 32'h0;
    logic [31:0] fix_rdata = 32'hCAFE0001;

    logic [31:0] tb_mem  [0:63];
    logic [31:0] ref_mem [0:63];

    typedef struct {
        logic        port;
        int          exp_cyc;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } sb_t;
    sb_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int en_cnt  = 0;
    int we_cnt  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .reset(rst_n),
        .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .reset(rst_n),
        .c_req(x1_c_req), .c_we(zero_b), .c_adr(zero_w), .c_wdata(zero_w),
        .c_ack(x1_c_ack), .c_rdata(x1_c_rdata),
        .d_req(zero_b), .d_we(zero_b), .d_adr(zero_w), .d_wdata(zero_w),
        .d_ack(x1_d_ack), .d_rdata(x1_d_rdata),
        .mem_en(x1_mem_en), .mem_we(x1_mem_we), .mem_adr(x1_mem_adr),
        .mem_wdata(x1_mem_wdata), .mem_rdata(fix_rdata), .owner(x1_owner)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(15)) u_dut_w15 (
        .clk(clk), .reset(rst_n),
        .c_req(x15_c_req), .c_we(zero_b), .c_adr(zero_w), .c_wdata(zero_w),
        .c_ack(x15_c_ack), .c_rdata(x15_c_rdata),
        .d_req(zero_b), .d_we(zero_b), .d_adr(zero_w), .d_wdata(zero_w),
        .d_ack(x15_d_ack), .d_rdata(x15_d_rdata),
        .mem_en(x15_mem_en), .mem_we(x15_mem_we), .mem_adr(x15_mem_adr),
        .mem_wdata(x15_mem_wdata), .mem_rdata(fix_rdata), .owner(x15_owner)
    );

    // Memory behind the main DUT: combinational read, write on the strobe.
    assign mem_rdata = tb_mem[mem_adr[7:2]];
    always @(posedge clk) if (mem_we) tb_mem[mem_adr[7:2]] <= mem_wdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic port, input int exp_cyc, input logic we,
                            input logic [31:0] adr, input logic [31:0] wdata);
        sb_t e;
        e.port    = port;
        e.exp_cyc = exp_cyc;
        e.we      = we;
        e.adr     = adr;
        e.wdata   = wdata;
        e.rdata   = we ? 32'h0 : ref_mem[adr[7:2]];
        if (we) ref_mem[adr[7:2]] = wdata;
        sb_q.push_back(e);
    endtask

    // Single uncontended access on one port, then a mandatory idle cycle.
    task automatic access(input logic port, input logic we, input logic [31:0] adr,
                          input logic [31:0] wdata);
        if (port) begin
            d_we = we; d_adr = adr; d_wdata = wdata; d_req = 1'b1;
        end else begin
            c_we = we; c_adr = adr; c_wdata = wdata; c_req = 1'b1;
        end
        push_exp(port, cyc + W, we, adr, wdata);
        tick(W + 1);
        c_req = 1'b0;
        d_req = 1'b0;
        tick(1);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            en_cnt = 0;
            we_cnt = 0;
        end else begin
            if (mem_en) en_cnt++;
            if (mem_we) we_cnt++;
            if (c_ack && d_ack) check_eq("dual_ack", 32'd1, 32'd0);
            if (c_ack || d_ack) begin
                if (sb_q.size() == 0) begin
                    check_eq("spurious_ack", {31'd0, d_ack}, 32'hFFFF_FFFF);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    check_eq("ack_port",  {31'd0, d_ack}, {31'd0, e.port});
                    check_eq("ack_cycle", 32'(cyc), 32'(e.exp_cyc));
                    check_eq("ack_owner", {31'd0, owner}, {31'd0, e.port});
                    check_eq("ack_adr",   mem_adr, e.adr);
                    check_eq("ack_rdata", e.port ? d_rdata : c_rdata, e.rdata);
                    check_eq("en_width",  32'(en_cnt), 32'(W));
                    check_eq("we_width",  32'(we_cnt), {31'd0, e.we});
                    if (e.we) check_eq("ack_wdata", mem_wdata, e.wdata);
                end
                en_cnt = 0;
                we_cnt = 0;
            end
        end
    end

    initial begin
        int k;
        int ack1_cyc, ack15_cyc, ack1_n, ack15_n, en1, en15;
        logic [31:0] rd1, rd15;

        for (int i = 0; i < 64; i++) begin
            tb_mem[i]  = 32'h1000_0000 + 32'(i);
            ref_mem[i] = 32'h1000_0000 + 32'(i);
        end
        tb_mem[4]  = 32'hDEADBEEF; ref_mem[4]  = 32'hDEADBEEF;
        tb_mem[6]  = 32'h1111_2222; ref_mem[6]  = 32'h1111_2222;

        rst_n = 1'b0;
        c_req = 0; c_we = 0; c_adr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_adr = 0; d_wdata = 0;
        x1_c_req = 0; x15_c_req = 0;
        tick(2);
        check_eq("rst_c_ack",     {31'd0, c_ack},  32'd0);
        check_eq("rst_d_ack",     {31'd0, d_ack},  32'd0);
        check_eq("rst_mem_en",    {31'd0, mem_en}, 32'd0);
        check_eq("rst_mem_we",    {31'd0, mem_we}, 32'd0);
        check_eq("rst_mem_adr",   mem_adr,         32'd0);
        check_eq("rst_mem_wdata", mem_wdata,       32'd0);
        check_eq("rst_c_rdata",   c_rdata,         32'd0);
        check_eq("rst_d_rdata",   d_rdata,         32'd0);
        check_eq("rst_owner",     {31'd0, owner},  32'd1);
        rst_n = 1'b1;
        tick(2);

        access(1'b0, 1'b0, 32'h10, 32'h0);
        access(1'b0, 1'b1, 32'h20, 32'h5);
        access(1'b0, 1'b0, 32'h20, 32'h0);
        access(1'b1, 1'b1, 32'h28, 32'hA5A5_0F0F);
        access(1'b1, 1'b0, 32'h28, 32'h0);

        // Field and request changes during ACCESS must not disturb the grant.
        c_we = 0; c_adr = 32'h10; c_req = 1'b1;
        k = cyc;
        push_exp(1'b0, k + 2, 1'b0, 32'h10, 32'h0);
        tick(1);
        c_adr = 32'h30;
        d_we = 0; d_adr = 32'h18; d_req = 1'b1;
        push_exp(1'b1, k + 5, 1'b0, 32'h18, 32'h0);
        tick(2);
        c_req = 1'b0;
        tick(3);
        d_req = 1'b0;
        tick(1);

        // Request dropped before ack still completes the write.
        c_we = 1; c_adr = 32'h24; c_wdata = 32'h77; c_req = 1'b1;
        push_exp(1'b0, cyc + 2, 1'b1, 32'h24, 32'h77);
        tick(1);
        c_req = 1'b0; c_wdata = 32'hBAD0_BAD0;
        tick(3);

        // Reset in the first ACCESS cycle of a write.
        c_we = 1; c_adr = 32'h24; c_wdata = 32'h99; c_req = 1'b1;
        tick(1);
        check_eq("pre_rst_mem_we", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        c_req = 1'b0;
        #1;
        check_eq("midrst_mem_en", {31'd0, mem_en}, 32'd0);
        check_eq("midrst_mem_we", {31'd0, mem_we}, 32'd0);
        check_eq("midrst_c_ack",  {31'd0, c_ack},  32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        check_eq("postrst_owner",  {31'd0, owner},  32'd1);
        check_eq("postrst_mem_en", {31'd0, mem_en}, 32'd0);

        // Contention straight after reset: C, D, C.
        c_we = 0; c_adr = 32'h10; c_req = 1'b1;
        d_we = 0; d_adr = 32'h18; d_req = 1'b1;
        k = cyc;
        push_exp(1'b0, k + 2, 1'b0, 32'h10, 32'h0);
        push_exp(1'b1, k + 5, 1'b0, 32'h18, 32'h0);
        push_exp(1'b0, k + 8, 1'b0, 32'h10, 32'h0);
        tick(6);
        d_req = 1'b0;
        tick(3);
        c_req = 1'b0;
        tick(1);

        access(1'b0, 1'b0, 32'h24, 32'h0);
        tick(2);
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

        // Latency extremes on the WAIT_CYCLES=1 and 15 instances.
        x1_c_req = 1'b1; x15_c_req = 1'b1;
        k = cyc;
        ack1_cyc = -1; ack15_cyc = -1; ack1_n = 0; ack15_n = 0; en1 = 0; en15 = 0;
        rd1 = 32'h0; rd15 = 32'h0;
        tick(1);
        x1_c_req = 1'b0; x15_c_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (x1_mem_en)  en1++;
            if (x15_mem_en) en15++;
            if (x1_c_ack)  begin ack1_n++;  ack1_cyc = cyc;  rd1 = x1_c_rdata;  end
            if (x15_c_ack) begin ack15_n++; ack15_cyc = cyc; rd15 = x15_c_rdata; end
        end
        check_eq("w1_ack_cycle",  32'(ack1_cyc),  32'(k + 1));
        check_eq("w1_ack_count",  32'(ack1_n),    32'd1);
        check_eq("w1_en_width",   32'(en1),       32'd1);
        check_eq("w1_rdata",      rd1,            32'hCAFE0001);
        check_eq("w15_ack_cycle", 32'(ack15_cyc), 32'(k + 15));
        check_eq("w15_ack_count", 32'(ack15_n),   32'd1);
        check_eq("w15_en_width",  32'(en15),      32'd15);
        check_eq("w15_rdata",     rd15,           32'hCAFE0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
